// File: rtl/mem_access_unit.sv
// Load/store bridge between the CPU datapath and a byte-enabled, one-cycle-latency memory.
// Handles lane steering, load extension/merge, alignment checks and an optional bus timeout.
module mem_access_unit #(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [1:0] {IDLE, BUS, RDATA, RESP} state_t;

    state_t      state_reg;
    logic [2:0]  op_reg;
    logic        write_reg;
    logic [1:0]  k_reg;
    logic [31:0] rt_reg;
    logic [31:0] cnt_reg;

    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_err_reg;
    logic [31:0] mem_address_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic [3:0]  mem_byteenable_reg;
    logic [31:0] mem_writedata_reg;

    logic [1:0]  k_next;
    logic [3:0]  be_next;
    logic [31:0] wrep_next;
    logic [31:0] wdata_next;
    logic        legal_next;
    logic [31:0] shr_data;
    logic [15:0] half_data;
    logic [4:0]  lwl_shift;
    logic [31:0] load_fmt;

    assign req_ready      = req_ready_reg;
    assign resp_valid     = resp_valid_reg;
    assign resp_rdata     = resp_rdata_reg;
    assign resp_err       = resp_err_reg;
    assign mem_address    = mem_address_reg;
    assign mem_read       = mem_read_reg;
    assign mem_write      = mem_write_reg;
    assign mem_byteenable = mem_byteenable_reg;
    assign mem_writedata  = mem_writedata_reg;

    // Request decode: lane enables, replicated store data and legality.
    always_comb begin
        k_next     = req_addr[1:0];
        be_next    = 4'b1111;
        wrep_next  = req_wdata;
        legal_next = 1'b0;
        case (req_op[1:0])
            2'b00: begin
                be_next   = 4'b0001 << k_next;
                wrep_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_next   = k_next[1] ? 4'b1100 : 4'b0011;
                wrep_next = {2{req_wdata[15:0]}};
            end
            default: begin
                be_next   = 4'b1111;
                wrep_next = req_wdata;
            end
        endcase
        if (req_write) begin
            case (req_op)
                3'b000:  legal_next = 1'b1;
                3'b001:  legal_next = ~k_next[0];
                3'b010:  legal_next = (k_next == 2'b00);
                default: legal_next = 1'b0;
            endcase
        end else begin
            case (req_op)
                3'b000, 3'b100, 3'b110, 3'b111: legal_next = 1'b1;
                3'b001, 3'b101:                 legal_next = ~k_next[0];
                3'b010:                         legal_next = (k_next == 2'b00);
                default:                        legal_next = 1'b0;
            endcase
        end
    end

    // Bytes outside the enabled lanes are forced to zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_next[8*gi +: 8] = be_next[gi] ? wrep_next[8*gi +: 8] : 8'h00;
        end
    endgenerate

    // Load formatting; LWL shift is 8*(3-k), which equals 8*~k for a 2-bit k.
    always_comb begin
        shr_data  = mem_readdata >> {k_reg, 3'b000};
        half_data = k_reg[1] ? mem_readdata[31:16] : mem_readdata[15:0];
        lwl_shift = {~k_reg, 3'b000};
        load_fmt  = mem_readdata;
        case (op_reg)
            3'b000:  load_fmt = {{24{shr_data[7]}}, shr_data[7:0]};
            3'b100:  load_fmt = {24'h000000, shr_data[7:0]};
            3'b001:  load_fmt = {{16{half_data[15]}}, half_data};
            3'b101:  load_fmt = {16'h0000, half_data};
            3'b110:  load_fmt = (mem_readdata << lwl_shift)
                                | (rt_reg & ~(32'hFFFFFFFF << lwl_shift));
            3'b111:  load_fmt = shr_data
                                | (rt_reg & ~(32'hFFFFFFFF >> {k_reg, 3'b000}));
            default: load_fmt = mem_readdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg          <= IDLE;
            op_reg             <= 3'b000;
            write_reg          <= 1'b0;
            k_reg              <= 2'b00;
            rt_reg             <= 32'h0;
            cnt_reg            <= 32'h0;
            req_ready_reg      <= 1'b1;
            resp_valid_reg     <= 1'b0;
            resp_rdata_reg     <= 32'h0;
            resp_err_reg       <= 1'b0;
            mem_address_reg    <= 32'h0;
            mem_read_reg       <= 1'b0;
            mem_write_reg      <= 1'b0;
            mem_byteenable_reg <= 4'b0000;
            mem_writedata_reg  <= 32'h0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        op_reg        <= req_op;
                        write_reg     <= req_write;
                        k_reg         <= k_next;
                        rt_reg        <= req_rt;
                        cnt_reg       <= 32'h0;
                        req_ready_reg <= 1'b0;
                        if (legal_next) begin
                            mem_address_reg    <= {req_addr[31:2], 2'b00};
                            mem_byteenable_reg <= be_next;
                            mem_writedata_reg  <= wdata_next;
                            mem_read_reg       <= ~req_write;
                            mem_write_reg      <= req_write;
                            state_reg          <= BUS;
                        end else begin
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            state_reg      <= RESP;
                        end
                    end
                end
                BUS: begin
                    if (!mem_waitrequest) begin
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        if (write_reg) begin
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b0;
                            state_reg      <= RESP;
                        end else begin
                            state_reg <= RDATA;
                        end
                    end else if (BUS_TIMEOUT != 0 && cnt_reg == BUS_TIMEOUT - 1) begin
                        mem_read_reg   <= 1'b0;
                        mem_write_reg  <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= 1'b1;
                        state_reg      <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 32'h1;
                    end
                end
                RDATA: begin
                    resp_rdata_reg <= load_fmt;
                    resp_valid_reg <= 1'b1;
                    resp_err_reg   <= 1'b0;
                    state_reg      <= RESP;
                end
                default: begin
                    req_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the CPU datapath load/store logic and the byte-enabled memory with registered read data (one-cycle read latency).
- Accepts one load/store request at a time and drives a word-aligned, byteenable-qualified memory transaction, honouring waitrequest.
- Returns formatted load data: sign/zero extension, LWL/LWR merge. Also returns an error flag for misaligned or illegal requests.
- Address translation is not done here; the memory applies its own base offset.

Parameters:
- BUS_TIMEOUT, 0, cycles of continuous mem_waitrequest before the access is aborted with an error; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high
- req_write  in  1  1 = store, 0 = load
- req_op  in  3  000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned, 110 LWL, 111 LWR; 011 and 101-as-store rules are given under Behaviour
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_rt  in  32  current rt value, used as the merge source for LWL/LWR
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  formatted load result; holds its value until the next load response
- resp_err  out  1  qualified by resp_valid
- mem_address  out  32  {req_addr[31:2],2'b00}
- mem_read  out  1
- mem_write  out  1
- mem_byteenable  out  4
- mem_writedata  out  32
- mem_waitrequest  in  1
- mem_readdata  in  32  valid in the cycle after a read is accepted

Behaviour:
- Reset (reset==0 at a clk edge): state goes to IDLE. All outputs are 0 except req_ready=1. Timeout counter clears. Reset in any state aborts the access: mem_read/mem_write drop at that edge and no resp_valid is issued.
- FSM states: IDLE, BUS, RDATA, RESP. Accept happens in IDLE.
- Acceptance latches op, write, addr, wdata and rt, and evaluates legality:
  - Byte: any alignment.
  - Half: addr[0]==0.
  - Word: addr[1:0]==0.
  - LWL/LWR: any alignment, loads only.
  - op 011 is illegal.
  - Stores allow only 000/001/010; the unsigned and LWL/LWR encodings are illegal as stores.
  - Illegal request: go to RESP with resp_err=1, resp_rdata unchanged, no memory access.
  - Legal request: go to BUS.
- Byte lanes are little-endian with k = addr[1:0]:
  - Byte: byteenable = 1<<k, data in bits [8k+7:8k].
  - Half: byteenable = k[1] ? 1100 : 0011.
  - Word, LWL, LWR: byteenable = 1111.
  - Store data is replicated/shifted into the enabled lanes; bits in disabled lanes are 0.
- BUS state:
  - mem_read or mem_write is asserted. Address, byteenable and writedata are held stable while mem_waitrequest=1.
  - If mem_waitrequest=0: stores go to RESP, loads go to RDATA; the strobe drops at that edge.
  - If BUS_TIMEOUT!=0 and the counter reaches BUS_TIMEOUT while waitrequest is still high: drop the strobe, go to RESP with resp_err=1.
- RDATA state: capture mem_readdata and format it into resp_rdata. Formatting rules:
  - LB/LBU: extend byte k.
  - LH/LHU: extend half k[1].
  - LW: pass through.
  - LWL: (mem << 8*(3-k)) | (rt & ((1<<8*(3-k))-1)).
  - LWR: (mem >> 8k) | (rt & ~(32'hFFFFFFFF >> 8k)).
- RESP state: resp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
- Latency, with accept at cycle T and no wait:
  - Load: resp_valid at T+3.
  - Store: resp_valid at T+2.
  - Illegal: resp_valid at T+1.
  - Each waitrequest cycle adds one cycle.
- mem_read and mem_write are never both high. Neither is high outside BUS.

Test Plan:
- LW addr 32'hBFC00010, readdata 32'hDEADBEEF, no wait -> mem_address BFC00010, byteenable 1111, mem_read high for 1 cycle, resp_valid at T+3, rdata DEADBEEF, err 0.
- LB addr 32'hBFC00013, readdata 32'h80123456 -> byteenable 1000, rdata FFFFFF80. LBU at the same address -> 00000080.
- SH addr 32'hBFC00002, wdata 32'h1234ABCD -> mem_write 1, byteenable 1100, writedata ABCD0000, resp_valid at T+2, err 0.
- LH addr 32'hBFC00001 -> resp_valid and resp_err at T+1; mem_read/mem_write never asserted. Also SB with op 100 -> err at T+1.
- LWR addr k=1, readdata 44332211, rt AABBCCDD -> AA443322. LWL addr k=1 with the same data -> 2211CCDD.
- LW with waitrequest high for 3 cycles (BUS_TIMEOUT=0) -> address and strobes stable, resp at T+6. With BUS_TIMEOUT=2 -> err response, strobe dropped. reset=0 during BUS -> strobes 0 and req_ready 1 after that edge, no resp_valid.
